// File: rtl/tlc_timebase.sv
// ---------------------------------------------------------------------------
// tlc_timebase -- time base and input conditioning for a traffic-light
// controller.
//
// Produces a one-cycle tick every DIV clocks, a blink square wave that flips
// on every tick, and a 5-bit seconds countdown that steps down on ticks. The
// two car sensors and the reset pushbutton are synchronized and debounced.
// The button also yields a single-cycle click pulse on each debounced press.
//
// Parameters
//   DIV  clk cycles per tick period (2 .. 2^27)
//   DEB  cycles an input must stay stable before it is accepted (1 .. 2^24)
//
// Ports
//   clk         in   system clock
//   rst         in   synchronous, active-high reset
//   car_ns_raw  in   asynchronous NS car sensor
//   car_ew_raw  in   asynchronous EW car sensor
//   btn_raw     in   asynchronous reset pushbutton
//   timer_load  in   load timer_init into the countdown (wins over a tick)
//   timer_en    in   allow a decrement on the next tick
//   timer_init  in   [4:0] load value, in seconds
//   clk_slow    out  one-cycle tick strobe, once every DIV cycles
//   blink       out  square wave, period 2*DIV
//   timer_out   out  [4:0] current countdown value, saturates at 0
//   car_ns      out  debounced NS sensor level
//   car_ew      out  debounced EW sensor level
//   click_rst   out  one-cycle pulse after a debounced button press
// ---------------------------------------------------------------------------

// Synchronizer plus debouncer for one asynchronous input. The level output
// changes only after the synchronized input has disagreed with it for DEB
// consecutive cycles; any agreement in between restarts the count.
module tlc_debounce #(
  parameter int DEB = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level
);

  localparam int CW = (DEB > 1) ? $clog2(DEB) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB - 1);

  logic          meta;
  logic          sync;
  logic [CW-1:0] cnt;

  // Two-flop synchronizer; nothing downstream sees raw directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      sync <= 1'b0;
    end else begin
      meta <= raw;
      sync <= meta;
    end
  end

  // Stability counter: the compare against CNT_MAX uses the value before the
  // increment, which gives DEB+2 cycles from a raw change to a level change.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= {CW{1'b0}};
      level <= 1'b0;
    end else if (sync == level) begin
      cnt   <= {CW{1'b0}};
    end else if (cnt == CNT_MAX) begin
      level <= sync;
      cnt   <= {CW{1'b0}};
    end else begin
      cnt   <= cnt + CW'(1);
    end
  end

endmodule

module tlc_timebase #(
  parameter int DIV = 100_000_000,
  parameter int DEB = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       car_ns_raw,
  input  logic       car_ew_raw,
  input  logic       btn_raw,
  input  logic       timer_load,
  input  logic       timer_en,
  input  logic [4:0] timer_init,
  output logic       clk_slow,
  output logic       blink,
  output logic [4:0] timer_out,
  output logic       car_ns,
  output logic       car_ew,
  output logic       click_rst
);

  localparam int PW = $clog2(DIV);
  localparam logic [PW-1:0] PS_MAX  = PW'(DIV - 1);
  localparam logic [PW-1:0] PS_PRE  = PW'(DIV - 2);

  logic [PW-1:0] prescaler;
  logic          btn_level;
  logic          btn_prev;

  // Free-running prescaler 0..DIV-1; only rst restarts it.
  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler <= {PW{1'b0}};
    end else if (prescaler == PS_MAX) begin
      prescaler <= {PW{1'b0}};
    end else begin
      prescaler <= prescaler + PW'(1);
    end
  end

  // Registered tick: set on the edge where the prescaler moves to DIV-1, so
  // clk_slow is high exactly while prescaler == DIV-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_slow <= 1'b0;
    end else begin
      clk_slow <= (prescaler == PS_PRE);
    end
  end

  // Blink flips on the edge that ends each tick cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      blink <= 1'b0;
    end else if (clk_slow) begin
      blink <= ~blink;
    end else begin
      blink <= blink;
    end
  end

  // Countdown: load beats tick; decrement saturates at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer_out <= 5'd0;
    end else if (timer_load) begin
      timer_out <= timer_init;
    end else if (clk_slow && timer_en && (timer_out != 5'd0)) begin
      timer_out <= timer_out - 5'd1;
    end else begin
      timer_out <= timer_out;
    end
  end

  tlc_debounce #(.DEB(DEB)) u_db_ns (
    .clk   (clk),
    .rst   (rst),
    .raw   (car_ns_raw),
    .level (car_ns)
  );

  tlc_debounce #(.DEB(DEB)) u_db_ew (
    .clk   (clk),
    .rst   (rst),
    .raw   (car_ew_raw),
    .level (car_ew)
  );

  tlc_debounce #(.DEB(DEB)) u_db_btn (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_raw),
    .level (btn_level)
  );

  // Rising-edge detect on the debounced button. The pulse is informational
  // only: the prescaler and countdown keep running through it.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_prev  <= 1'b0;
      click_rst <= 1'b0;
    end else begin
      btn_prev  <= btn_level;
      click_rst <= btn_level & ~btn_prev;
    end
  end

endmodule

// File: tb/tb_tlc_timebase.sv
// Bench for tlc_timebase with DIV=4, DEB=3: a directed vector table for the
// tick, blink and countdown behaviour, plus hand sequences for debounce,
// button click and tick phase.
module tb_tlc_timebase;

  localparam int DIV = 4;
  localparam int DEB = 3;

  logic       clk;
  logic       rst;
  logic       car_ns_raw;
  logic       car_ew_raw;
  logic       btn_raw;
  logic       timer_load;
  logic       timer_en;
  logic [4:0] timer_init;
  logic       clk_slow;
  logic       blink;
  logic [4:0] timer_out;
  logic       car_ns;
  logic       car_ew;
  logic       click_rst;

  int n_vec;
  int n_err;
  int ek;     // edges since the last reset edge

  tlc_timebase #(.DIV(DIV), .DEB(DEB)) dut (
    .clk        (clk),
    .rst        (rst),
    .car_ns_raw (car_ns_raw),
    .car_ew_raw (car_ew_raw),
    .btn_raw    (btn_raw),
    .timer_load (timer_load),
    .timer_en   (timer_en),
    .timer_init (timer_init),
    .clk_slow   (clk_slow),
    .blink      (blink),
    .timer_out  (timer_out),
    .car_ns     (car_ns),
    .car_ew     (car_ew),
    .click_rst  (click_rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       ld;
    logic       en;
    logic [4:0] init;
    int         n;      // edges to run with these inputs before comparing
    logic       slow;
    logic       blink;
    logic [4:0] t;
  } vec_t;

  vec_t tbl[34];

  function automatic vec_t mk(input logic r, input logic ld, input logic en,
                              input logic [4:0] init, input int n,
                              input logic slow, input logic bl,
                              input logic [4:0] t);
    vec_t v;
    v.rst = r; v.ld = ld; v.en = en; v.init = init; v.n = n;
    v.slow = slow; v.blink = bl; v.t = t;
    return v;
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, got, exp, ek);
    end
  endtask

  task automatic clk_edge();
    @(posedge clk);
    if (rst) ek = 0;
    else ek++;
    #1;
  endtask

  // One edge plus a check of the tick phase against the edge count.
  task automatic step();
    clk_edge();
    chk("tick_phase", int'(clk_slow), int'((ek % DIV) == DIV - 1));
  endtask

  initial begin
    n_vec = 0; n_err = 0; ek = 0;
    rst = 1'b1; car_ns_raw = 1'b0; car_ew_raw = 1'b0; btn_raw = 1'b0;
    timer_load = 1'b0; timer_en = 1'b0; timer_init = 5'd0;

    //             rst   ld    en    init  n  slow  blink t
    tbl[0]  = mk(1'b1, 1'b0, 1'b0, 5'd0, 2, 1'b0, 1'b0, 5'd0); // reset
    tbl[1]  = mk(1'b0, 1'b0, 1'b0, 5'd0, 1, 1'b0, 1'b0, 5'd0); // cycle 2
    tbl[2]  = mk(1'b0, 1'b0, 1'b0, 5'd0, 1, 1'b0, 1'b0, 5'd0); // cycle 3
    tbl[3]  = mk(1'b0, 1'b0, 1'b0, 5'd0, 1, 1'b1, 1'b0, 5'd0); // cycle 4 tick
    tbl[4]  = mk(1'b0, 1'b0, 1'b0, 5'd0, 1, 1'b0, 1'b1, 5'd0);
    tbl[5]  = mk(1'b0, 1'b0, 1'b0, 5'd0, 3, 1'b1, 1'b1, 5'd0); // cycle 8
    tbl[6]  = mk(1'b0, 1'b0, 1'b0, 5'd0, 1, 1'b0, 1'b0, 5'd0);
    tbl[7]  = mk(1'b0, 1'b0, 1'b0, 5'd0, 3, 1'b1, 1'b0, 5'd0); // cycle 12
    tbl[8]  = mk(1'b0, 1'b0, 1'b0, 5'd0, 4, 1'b1, 1'b1, 5'd0); // cycle 16
    tbl[9]  = mk(1'b0, 1'b0, 1'b0, 5'd0, 4, 1'b1, 1'b0, 5'd0); // cycle 20
    tbl[10] = mk(1'b0, 1'b0, 1'b0, 5'd0, 1, 1'b0, 1'b1, 5'd0);
    tbl[11] = mk(1'b0, 1'b1, 1'b0, 5'd5, 1, 1'b0, 1'b1, 5'd5); // load 5
    tbl[12] = mk(1'b0, 1'b0, 1'b1, 5'd0, 1, 1'b0, 1'b1, 5'd5);
    tbl[13] = mk(1'b0, 1'b0, 1'b1, 5'd0, 1, 1'b1, 1'b1, 5'd5);
    tbl[14] = mk(1'b0, 1'b0, 1'b1, 5'd0, 1, 1'b0, 1'b0, 5'd4);
    tbl[15] = mk(1'b0, 1'b0, 1'b1, 5'd0, 4, 1'b0, 1'b1, 5'd3);
    tbl[16] = mk(1'b0, 1'b0, 1'b1, 5'd0, 4, 1'b0, 1'b0, 5'd2);
    tbl[17] = mk(1'b0, 1'b0, 1'b1, 5'd0, 4, 1'b0, 1'b1, 5'd1);
    tbl[18] = mk(1'b0, 1'b0, 1'b1, 5'd0, 4, 1'b0, 1'b0, 5'd0);
    tbl[19] = mk(1'b0, 1'b0, 1'b1, 5'd0, 4, 1'b0, 1'b1, 5'd0); // saturate
    tbl[20] = mk(1'b0, 1'b0, 1'b1, 5'd0, 4, 1'b0, 1'b0, 5'd0);
    tbl[21] = mk(1'b0, 1'b0, 1'b1, 5'd0, 4, 1'b0, 1'b1, 5'd0);
    tbl[22] = mk(1'b0, 1'b1, 1'b1, 5'd3, 1, 1'b0, 1'b1, 5'd3); // load 3
    tbl[23] = mk(1'b0, 1'b0, 1'b1, 5'd0, 2, 1'b1, 1'b1, 5'd3); // tick, t=3
    tbl[24] = mk(1'b0, 1'b1, 1'b1, 5'd9, 1, 1'b0, 1'b0, 5'd9); // load wins
    tbl[25] = mk(1'b0, 1'b1, 1'b1, 5'd9, 4, 1'b0, 1'b1, 5'd9); // held load
    tbl[26] = mk(1'b0, 1'b0, 1'b0, 5'd0, 4, 1'b0, 1'b0, 5'd9); // en=0 hold
    tbl[27] = mk(1'b0, 1'b1, 1'b0, 5'd7, 1, 1'b0, 1'b0, 5'd7);
    tbl[28] = mk(1'b0, 1'b0, 1'b0, 5'd0, 3, 1'b0, 1'b1, 5'd7); // t=7 blink=1
    tbl[29] = mk(1'b1, 1'b1, 1'b1, 5'd9, 1, 1'b0, 1'b0, 5'd0); // rst beats load
    tbl[30] = mk(1'b0, 1'b0, 1'b0, 5'd0, 1, 1'b0, 1'b0, 5'd0);
    tbl[31] = mk(1'b0, 1'b0, 1'b0, 5'd0, 1, 1'b0, 1'b0, 5'd0);
    tbl[32] = mk(1'b0, 1'b0, 1'b0, 5'd0, 1, 1'b1, 1'b0, 5'd0); // 4th cycle
    tbl[33] = mk(1'b0, 1'b0, 1'b0, 5'd0, 1, 1'b0, 1'b1, 5'd0);

    for (int i = 0; i < 34; i++) begin
      rst        = tbl[i].rst;
      timer_load = tbl[i].ld;
      timer_en   = tbl[i].en;
      timer_init = tbl[i].init;
      repeat (tbl[i].n) clk_edge();
      chk($sformatf("vec%0d {slow,blink,t,ns,ew,click}", i),
          int'({clk_slow, blink, timer_out, car_ns, car_ew, click_rst}),
          int'({tbl[i].slow, tbl[i].blink, tbl[i].t, 3'b000}));
    end
    rst = 1'b0; timer_load = 1'b0; timer_en = 1'b0; timer_init = 5'd0;

    // Glitch of 2 cycles on the NS sensor is swallowed.
    car_ns_raw = 1'b1;
    step(); step();
    car_ns_raw = 1'b0;
    for (int j = 1; j <= 8; j++) begin
      step();
      chk("ns_glitch", int'(car_ns), 0);
    end

    // Stable NS press: level rises 5 edges after the raw edge, falls likewise.
    car_ns_raw = 1'b1;
    for (int j = 1; j <= 10; j++) begin
      step();
      chk($sformatf("ns_rise_%0d", j), int'(car_ns), int'(j >= 5));
    end
    car_ns_raw = 1'b0;
    for (int j = 1; j <= 6; j++) begin
      step();
      chk($sformatf("ns_fall_%0d", j), int'(car_ns), int'(j < 5));
    end

    // EW sensor is independent of NS.
    car_ew_raw = 1'b1;
    for (int j = 1; j <= 6; j++) begin
      step();
      chk($sformatf("ew_rise_%0d", j), int'(car_ew), int'(j >= 5));
      chk("ns_quiet", int'(car_ns), 0);
    end
    car_ew_raw = 1'b0;
    repeat (6) step();
    chk("ew_fall", int'(car_ew), 0);

    // Button: one click 6 edges after the raw edge, none while held or on release;
    // the countdown is left untouched by the click.
    timer_load = 1'b1; timer_init = 5'd13;
    step();
    timer_load = 1'b0; timer_init = 5'd0;
    btn_raw = 1'b1;
    for (int j = 1; j <= 20; j++) begin
      step();
      chk($sformatf("click_%0d", j), int'(click_rst), int'(j == 6));
    end
    btn_raw = 1'b0;
    for (int j = 1; j <= 12; j++) begin
      step();
      chk("click_release", int'(click_rst), 0);
    end
    chk("timer_after_click", int'(timer_out), 13);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
